ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, meaning the data word width.
REQ-002 The block SHALL provide parameter ADDR_W, default 4, meaning the RAM address width; depth is 2**ADDR_W = 16.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port push  input  1  is the write request from the producer.
REQ-006 Port push_data  input  DATA_W  is the write data.
REQ-007 Port pop  input  1  is the read request from the consumer.
REQ-008 Port pop_data  output  DATA_W  is the read data, valid when pop_valid=1.
REQ-009 Port pop_valid  output  1  flags that pop_data holds a popped word.
REQ-010 Port full  output  1  is high when count = 16.
REQ-011 Port empty  output  1  is high when count = 0.
REQ-012 Port count  output  ADDR_W+1  is the occupancy, 0..16.
REQ-013 Port overflow  output  1  is a one-cycle pulse for a rejected push.
REQ-014 Port underflow  output  1  is a one-cycle pulse for a rejected pop.
REQ-015 Port ram_wr_en  output  1  drives the dual-port RAM write enable.
REQ-016 Port ram_wr_addr  output  ADDR_W  drives the RAM write address.
REQ-017 Port ram_din  output  DATA_W  drives the RAM write data.
REQ-018 Port ram_rd_en  output  1  drives the RAM read enable.
REQ-019 Port ram_rd_addr  output  ADDR_W  drives the RAM read address.
REQ-020 Port ram_dout  input  DATA_W  carries the RAM registered read data (1-cycle latency).

Function
REQ-021 A push SHALL be accepted iff push=1 and full=0; a pop SHALL be accepted iff pop=1 and empty=0. Decisions use the pre-edge flags.
REQ-022 On an accepted push, the block SHALL drive ram_wr_en=1, ram_wr_addr=wr_ptr and ram_din=push_data in the same cycle (combinational), and wr_ptr SHALL increment at the edge.
REQ-023 On an accepted pop, the block SHALL drive ram_rd_en=1 and ram_rd_addr=rd_ptr in the same cycle, and rd_ptr SHALL increment at the edge.
REQ-024 ram_wr_en and ram_rd_en SHALL be 0 in any cycle without an accepted push or pop, respectively.
REQ-025 wr_ptr and rd_ptr SHALL wrap modulo 16 (15 -> 0) with no other effect.
REQ-026 count SHALL change by +1 (push only), -1 (pop only), or 0 (both accepted, or neither accepted).
REQ-027 full and empty SHALL be registered, consistent with count in the same cycle.
REQ-028 pop_valid SHALL be 1 exactly in the cycle after an accepted pop. pop_data SHALL equal ram_dout in that cycle, and SHALL hold its last value otherwise.
REQ-029 When full with push=1 and pop=1, the pop SHALL be accepted and the push rejected (overflow pulse); count becomes 15.
REQ-030 When empty with push=1 and pop=1, the push SHALL be accepted and the pop rejected (underflow pulse, no bypass); count becomes 1.
REQ-031 overflow and underflow SHALL be registered and asserted for exactly one cycle following each rejected request. State SHALL be unchanged by a rejected request.
REQ-032 Data SHALL be popped in strict push order.
REQ-033 A word written at edge N SHALL be readable from edge N+1; this is guaranteed by REQ-021.

Reset
REQ-034 While rst_n=0, all of the following SHALL hold, independent of clk:
- wr_ptr=0, rd_ptr=0, count=0;
- empty=1, full=0;
- pop_valid=0, overflow=0, underflow=0;
- pop_data=0;
- ram_wr_en=0, ram_rd_en=0.
REQ-035 A reset mid-operation SHALL logically discard all stored words. RAM contents are not cleared. A pop_valid pending from the pre-reset cycle SHALL be suppressed.
REQ-036 The first push or pop SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-037 The bench SHALL cover: reset, then push 16 words 0x00..0x0F on consecutive cycles -> count=16 and full=1 after the 16th edge; ram_wr_addr sequence 0..15.
REQ-038 The bench SHALL cover: from full, pop 16 times -> pop_valid on 16 consecutive cycles with pop_data 0x00..0x0F in order, then empty=1 and count=0.
REQ-039 The bench SHALL cover: push 0xAA while full -> overflow pulse 1 cycle, count stays 16, ram_wr_en=0.
REQ-040 The bench SHALL cover: pop while empty -> underflow pulse 1 cycle, no pop_valid, ram_rd_en=0.
REQ-041 The bench SHALL cover: at count=5, push and pop simultaneously for 20 cycles -> count stays 5, both pointers wrap past 15, and data order is preserved.
REQ-042 The bench SHALL cover: push 3 words, assert rst_n=0 mid-cycle -> empty=1, count=0 immediately, and no pop_valid after release.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller wrapped around an external dual-port RAM with registered read
//
// Purpose:
//   Keeps the write and read pointers and the occupancy count for a FIFO
//   whose storage is an external dual-port RAM. The RAM has one cycle of
//   read latency, and the popped word comes back on pop_data in the cycle
//   after the pop is accepted.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   push, push_data         producer write request and data
//   pop                     consumer read request
//   pop_data, pop_valid     popped word, valid for one cycle after an accepted pop
//   full, empty, count      registered occupancy status (count is 0..DEPTH)
//   overflow, underflow     one-cycle pulses after a rejected push or pop
//   ram_wr_en/addr, ram_din RAM write port (combinational from the request)
//   ram_rd_en/addr          RAM read port (combinational from the request)
//   ram_dout                RAM registered read data

module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W:0] DEPTH = ADDR_W'(1) << ADDR_W;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              full_q,   empty_q;
    logic              pop_valid_q;
    logic [DATA_W-1:0] pop_hold_q;
    logic              overflow_q, underflow_q;

    logic push_ok, pop_ok;

    // Decisions use the registered flags of the current cycle. Gating with
    // rst_n keeps the RAM strobes low while reset is held even if the
    // requesters are active. With both requests present, full rejects the
    // push and empty rejects the pop, so a read never bypasses a write.
    assign push_ok = rst_n & push & ~full_q;
    assign pop_ok  = rst_n & pop  & ~empty_q;

    // Next-state logic. The pointers are exactly ADDR_W bits wide, so they
    // wrap modulo the depth without any extra handling.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pop_valid_q <= 1'b0;
            pop_hold_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            // Flags come from the next count so they agree with count in
            // every cycle.
            full_q      <= (count_d == DEPTH);
            empty_q     <= (count_d == '0);
            pop_valid_q <= pop_ok;
            overflow_q  <= push & ~push_ok;
            underflow_q <= pop  & ~pop_ok;
            // Remember the word delivered this cycle so pop_data holds it
            // once pop_valid drops.
            if (pop_valid_q) begin
                pop_hold_q <= ram_dout;
            end
        end
    end

    // RAM ports: driven in the same cycle as the accepted request.
    assign ram_wr_en   = push_ok;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_din     = push_data;
    assign ram_rd_en   = pop_ok;
    assign ram_rd_addr = rd_ptr_q;

    // The RAM output register already holds the popped word in the valid
    // cycle; passing it straight through avoids a second cycle of latency.
    assign pop_data  = pop_valid_q ? ram_dout : pop_hold_q;
    assign pop_valid = pop_valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl with a queue-based reference model
module tb_ram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push, pop;
    logic [DW-1:0] push_data;
    logic [DW-1:0] pop_data;
    logic          pop_valid, full, empty, overflow, underflow;
    logic [AW:0]   count;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_din, ram_dout;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout)
    );

    // External dual-port RAM with a registered read port.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
    end

    // Reference model: a plain queue of words plus the expected pulses.
    logic [DW-1:0] mq[$];
    int            m_wr, m_rd;
    logic          m_valid, m_ovf, m_unf;
    logic [DW-1:0] m_pdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_wr    <= 0;
            m_rd    <= 0;
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
            m_pdata <= '0;
        end else begin
            automatic bit acc_push = push && (mq.size() < DEPTH);
            automatic bit acc_pop  = pop  && (mq.size() > 0);
            m_valid <= acc_pop;
            m_ovf   <= push && !acc_push;
            m_unf   <= pop  && !acc_pop;
            if (acc_pop) begin
                m_pdata <= mq[0];
                void'(mq.pop_front());
                m_rd <= (m_rd + 1) % DEPTH;
            end
            if (acc_push) begin
                mq.push_back(push_data);
                m_wr <= (m_wr + 1) % DEPTH;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        automatic bit e_wr = rst_n && push && (mq.size() < DEPTH);
        automatic bit e_rd = rst_n && pop  && (mq.size() > 0);
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("pop_valid", 32'(pop_valid), 32'(m_valid));
        chk("pop_data", 32'(pop_data), 32'(m_pdata));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(e_wr));
        chk("ram_rd_en", 32'(ram_rd_en), 32'(e_rd));
        if (e_wr) begin
            chk("ram_wr_addr", 32'(ram_wr_addr), 32'(m_wr));
            chk("ram_din", 32'(ram_din), 32'(push_data));
        end
        if (e_rd) chk("ram_rd_addr", 32'(ram_rd_addr), 32'(m_rd));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b1; pop = 1'b1; push_data = 8'h55;
        step(); step();
        // Reset state, with both requests active to show the strobes stay low.
        chk("rst count", 32'(count), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst full", 32'(full), 0);
        chk("rst pop_valid", 32'(pop_valid), 0);
        chk("rst pop_data", 32'(pop_data), 0);
        chk("rst ram_wr_en", 32'(ram_wr_en), 0);
        chk("rst ram_rd_en", 32'(ram_rd_en), 0);
        push = 1'b0; pop = 1'b0;
        rst_n = 1'b1;

        // Fill with 0x00..0x0F; the first push lands on the first edge after release.
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; push_data = 8'(i);
            #1 chk("fill wr_addr", 32'(ram_wr_addr), i);
            step();
        end
        push = 1'b0;
        chk("fill count", 32'(count), 16);
        chk("fill full", 32'(full), 1);

        // Push while full.
        push = 1'b1; push_data = 8'hAA;
        #1 chk("ovf ram_wr_en", 32'(ram_wr_en), 0);
        step();
        push = 1'b0;
        chk("ovf pulse", 32'(overflow), 1);
        chk("ovf count", 32'(count), 16);
        step();
        chk("ovf pulse end", 32'(overflow), 0);

        // Drain in order.
        pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain pop_valid", 32'(pop_valid), 1);
            chk("drain pop_data", 32'(pop_data), i);
        end
        pop = 1'b0;
        chk("drain empty", 32'(empty), 1);
        chk("drain count", 32'(count), 0);
        step();
        chk("drain valid end", 32'(pop_valid), 0);
        chk("drain data hold", 32'(pop_data), 8'h0F);

        // Pop while empty.
        pop = 1'b1;
        #1 chk("unf ram_rd_en", 32'(ram_rd_en), 0);
        step();
        pop = 1'b0;
        chk("unf pulse", 32'(underflow), 1);
        chk("unf pop_valid", 32'(pop_valid), 0);
        step();
        chk("unf pulse end", 32'(underflow), 0);

        // Occupancy 5, then 20 cycles of simultaneous push and pop (pointers wrap).
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = 8'(100 + i);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            push = 1'b1; pop = 1'b1; push_data = 8'(200 + i);
            step();
            chk("simul count", 32'(count), 5);
            if (i == 0) chk("simul first data", 32'(pop_data), 100);
        end
        push = 1'b0;
        for (int i = 0; i < 5; i++) step();
        pop = 1'b0;
        chk("simul last data", 32'(pop_data), 219);
        chk("simul empty", 32'(empty), 1);
        step();

        // Push and pop together while empty: push wins, pop underflows.
        push = 1'b1; pop = 1'b1; push_data = 8'h33;
        step();
        push = 1'b0; pop = 1'b0;
        chk("empty both count", 32'(count), 1);
        chk("empty both unf", 32'(underflow), 1);
        chk("empty both valid", 32'(pop_valid), 0);

        // Three words stored, one pop in flight, then reset mid-cycle.
        for (int i = 0; i < 2; i++) begin
            push = 1'b1; push_data = 8'(i + 1);
            step();
        end
        push = 1'b0; pop = 1'b1;
        step();
        pop = 1'b0;
        chk("pre-rst pop_valid", 32'(pop_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-rst empty", 32'(empty), 1);
        chk("mid-rst count", 32'(count), 0);
        chk("mid-rst pop_valid", 32'(pop_valid), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post-rst pop_valid", 32'(pop_valid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
